// File: rtl/mult_div_if.sv
// Request/result bundle for the HI/LO multiply-divide unit.
// The requester drives start/op/a/b; the unit returns busy/done/hi/lo.
interface mult_div_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mult_div.sv
// MIPS-style HI/LO unit: single-cycle multiply, MTHI/MTLO, and a 32-step
// restoring divider that writes quotient to LO and remainder to HI.
module mult_div (
    input  logic         clk,
    input  logic         reset,
    mult_div_if.slave    bus
);
    localparam logic [2:0] OP_MULTU = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE, DIV} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  count_reg;
    logic [31:0] hi_reg, lo_reg;
    logic        done_reg;
    logic [31:0] quot_reg, rem_reg, divisor_reg;
    logic        neg_q_reg, neg_r_reg, div_zero_reg;

    logic        accept, is_div_op, is_signed_div;
    logic [63:0] ext_a, ext_b, product;
    logic [31:0] mag_a, mag_b;
    logic [32:0] shifted;
    logic        ge;
    logic [31:0] rem_next, quot_next;

    always_comb begin
        accept        = bus.start && (state_reg == IDLE) && (bus.op <= OP_MTLO);
        is_div_op     = (bus.op == OP_DIVU) || (bus.op == OP_DIV);
        is_signed_div = (bus.op == OP_DIV);
    end

    // One 64x64 multiplier serves both flavours: the low 64 bits of the
    // product of sign-extended operands are the signed 64-bit result.
    always_comb begin
        if (bus.op == OP_MULT) begin
            ext_a = {{32{bus.a[31]}}, bus.a};
            ext_b = {{32{bus.b[31]}}, bus.b};
        end else begin
            ext_a = {32'd0, bus.a};
            ext_b = {32'd0, bus.b};
        end
        product = ext_a * ext_b;
    end

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    always_comb begin
        mag_a = (is_signed_div && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
        mag_b = (is_signed_div && bus.b[31]) ? (32'd0 - bus.b) : bus.b;
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits.
    always_comb begin
        shifted   = {rem_reg, quot_reg[31]};
        ge        = (shifted >= {1'b0, divisor_reg});
        rem_next  = ge ? 32'(shifted - {1'b0, divisor_reg}) : shifted[31:0];
        quot_next = {quot_reg[30:0], ge};
    end

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept && is_div_op) state_next = DIV;
            DIV:     if (count_reg == 5'd31) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_reg       <= 32'd0;
            lo_reg       <= 32'd0;
            done_reg     <= 1'b0;
            count_reg    <= 5'd0;
            quot_reg     <= 32'd0;
            rem_reg      <= 32'd0;
            divisor_reg  <= 32'd0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (state_reg == IDLE) begin
                if (accept) begin
                    case (bus.op)
                        OP_MULTU, OP_MULT: begin
                            hi_reg   <= product[63:32];
                            lo_reg   <= product[31:0];
                            done_reg <= 1'b1;
                        end
                        OP_MTHI: hi_reg <= bus.a;
                        OP_MTLO: lo_reg <= bus.a;
                        OP_DIVU, OP_DIV: begin
                            quot_reg     <= mag_a;
                            rem_reg      <= 32'd0;
                            divisor_reg  <= mag_b;
                            neg_q_reg    <= is_signed_div && (bus.a[31] ^ bus.b[31]);
                            neg_r_reg    <= is_signed_div && bus.a[31];
                            div_zero_reg <= (bus.b == 32'd0);
                            count_reg    <= 5'd0;
                        end
                        default: ;
                    endcase
                end
            end else begin
                quot_reg  <= quot_next;
                rem_reg   <= rem_next;
                count_reg <= count_reg + 5'd1;
                if (count_reg == 5'd31) begin
                    done_reg <= 1'b1;
                    // Divide by zero still runs the full period but leaves HI/LO alone.
                    if (!div_zero_reg) begin
                        lo_reg <= neg_q_reg ? (32'd0 - quot_next) : quot_next;
                        hi_reg <= neg_r_reg ? (32'd0 - rem_next) : rem_next;
                    end
                end
            end
        end
    end

    assign bus.busy = (state_reg == DIV);
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;
endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request strobe, sampled on rising clk edges.
REQ-005 op  input  3  operation code: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO; 6 and 7 are invalid.
REQ-006 a  input  32  rs operand: dividend, multiplicand, or MTHI/MTLO source.
REQ-007 b  input  32  rt operand: divisor or multiplier.
REQ-008 busy  output  1  high while a division is in progress.
REQ-009 done  output  1  single-cycle completion pulse.
REQ-010 hi  output  32  registered HI register.
REQ-011 lo  output  32  registered LO register.

Function
REQ-012 The block SHALL have two states, IDLE and DIV.
REQ-013 A request SHALL be accepted only on an edge where start=1, state=IDLE and op is 0-5.
  - Requests with op 6 or 7 SHALL be ignored with no state change.
  - Requests made while in state DIV SHALL be ignored with no state change.
REQ-014 MULTU: the accepting edge SHALL load {hi,lo} with the 64-bit unsigned product a*b.
  - done=1 in the following cycle; busy stays 0.
REQ-015 MULT: the same as MULTU, but a and b are treated as two's-complement and the signed 64-bit product is loaded.
REQ-016 MTHI: the accepting edge SHALL load hi with a; lo is unchanged; no done pulse.
REQ-017 MTLO: the accepting edge SHALL load lo with a; hi is unchanged; no done pulse.
REQ-018 DIVU/DIV accepting edge:
  - SHALL latch the operands and operation into working registers.
  - SHALL clear the iteration counter (5 bits) and enter state DIV.
  - The operand ports may change after this edge without effect.
REQ-019 busy SHALL equal (state==DIV), so it is high for exactly 32 cycles, starting the cycle after the accepting edge.
REQ-020 Iteration:
  - Each edge in state DIV SHALL perform one restoring shift/subtract step on the operand magnitudes.
  - Each such edge SHALL increment the counter.
REQ-021 Completion edge (counter==31):
  - SHALL load lo with the quotient and hi with the remainder.
  - SHALL return the state to IDLE.
  - done=1 in the following cycle.
REQ-022 hi and lo SHALL hold their previous values throughout a division until the completion edge.
REQ-023 DIV sign rules:
  - Quotient is negated if the signs of a and b differ.
  - Remainder takes the sign of a.
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
REQ-024 DIV with a=0x80000000, b=0xFFFFFFFF SHALL yield lo=0x80000000, hi=0 (wrap, no trap).
REQ-025 Divide by zero (b=0, DIVU or DIV):
  - The full 32-cycle busy period SHALL still run.
  - hi and lo SHALL remain unchanged.
  - done SHALL still pulse.
REQ-026 done SHALL be high for exactly one cycle per accepted MULT, MULTU, DIV or DIVU, and low at all other times.
REQ-027 A new request accepted in the cycle where done=1 SHALL be legal and processed normally.

Reset
REQ-028 On a clock edge with reset=1, the block SHALL:
  - set hi=0, lo=0, busy=0, done=0;
  - set state=IDLE and counter=0;
  - ignore start on that edge.
REQ-029 Reset asserted during a division SHALL abort it with no result written and no done pulse.
REQ-030 reset SHALL take priority over start on the same edge.

Verification
REQ-031 MULTU a=0xFFFFFFFF, b=0x2 -> next cycle hi=0x00000001, lo=0xFFFFFFFE, done=1 for one cycle, busy=0 throughout.
REQ-032 MULT a=0xFFFFFFFD (-3), b=0x5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then MTHI a=0x11 -> hi=0x11, lo unchanged, done=0.
REQ-033 DIV a=0xFFFFFFF9 (-7), b=0x2 -> busy=1 for 32 cycles, hi/lo unchanged meanwhile, then lo=0xFFFFFFFD, hi=0xFFFFFFFF, done=1 one cycle.
REQ-034 MTHI 0x11, MTLO 0x22, then DIVU a=100, b=0 -> after 32 busy cycles hi=0x11, lo=0x22, done pulses; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 DIVU 100/7 accepted at cycle 0, MULTU start at cycle 5 -> ignored; result lo=14, hi=2, done at cycle 33 (one cycle after the completion edge closing the 32 busy cycles 1-32).
REQ-036 DIVU started, reset at cycle 10 -> next cycle hi=lo=0, busy=0, no done ever; a subsequent MULTU 3*4 gives lo=12, hi=0.
